uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit (even, >= 4).
REQ-002 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port data_o  output  8  received byte.
REQ-006 SHALL have port valid_o  output  1  data_o holds an undelivered byte.
REQ-007 SHALL have port ready_i  input  1  consumer accepts data_o when high with valid_o.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port parity_err_o  output  1  one-cycle pulse: parity mismatch; tied 0 when parity is compiled out.
REQ-010 SHALL have port overrun_o  output  1  one-cycle pulse: byte completed while buffer full.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; all timing below counts from the synchronized signal.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 IDLE: synced rx = 0 SHALL enter START and clear the bit-timer.
REQ-014 START: after CLKS_PER_BIT/2 cycles, rx = 0 SHALL enter DATA; rx = 1 SHALL return to IDLE with no outputs (glitch reject).
REQ-015 DATA: SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample (mid-bit).
REQ-016 After bit 7 SHALL enter PARITY when parity is enabled, else STOP.
REQ-017 PARITY: SHALL sample one bit CLKS_PER_BIT later and compare against even parity of the 8 data bits.
REQ-018 STOP: SHALL sample CLKS_PER_BIT later; rx = 1 SHALL deliver the byte and return to IDLE; rx = 0 SHALL pulse frame_err_o, drop the byte, and enter WAIT_IDLE.
REQ-019 WAIT_IDLE: SHALL stay until synced rx = 1, then enter IDLE.
REQ-020 Delivery SHALL occur the cycle after the stop-bit sample: data_o loaded, valid_o high.
REQ-021 valid_o and data_o SHALL hold stable until the cycle where valid_o & ready_i; valid_o SHALL clear the next cycle unless a new byte is delivered in that same cycle, in which case valid_o stays high with the new data.
REQ-022 If a byte completes while valid_o = 1 and ready_i = 0, SHALL drop the new byte, keep the old one, and pulse overrun_o.
REQ-023 A parity mismatch SHALL pulse parity_err_o at delivery time and drop the byte; frame error takes precedence, and only frame_err_o pulses when both occur.
REQ-024 Error/overrun pulses SHALL be exactly one cycle wide and never assert together with a new delivery.
REQ-025 The bit-timer SHALL be ceil(log2(CLKS_PER_BIT)) bits wide and reset to 0 on every state entry.

Reset
REQ-026 rst_n low SHALL asynchronously force: FSM = IDLE, timers/shift register = 0, data_o = 0x00, valid_o = 0, all error outputs = 0, synchronizer = 1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL wait for a new falling edge.

Configuration
REQ-028 Macro UART_RX_PARITY_EN defined: PARITY state present, frame = start + 8 data + even parity + stop.
REQ-029 Macro UART_RX_PARITY_EN undefined: no PARITY state, frame = start + 8 data + stop, parity_err_o constant 0.

Verification (CLKS_PER_BIT = 16)
REQ-030 Send 0xA5 (valid frame), ready_i = 1 -> valid_o high one cycle, data_o = 0xA5, no error pulses.
REQ-031 rx low for 4 cycles, then high -> no valid_o, no error pulses, FSM back in IDLE.
REQ-032 Send 0x3C with stop bit = 0, rx held low 40 more cycles -> frame_err_o single pulse, no valid_o; next valid frame 0x81 -> data_o = 0x81.
REQ-033 Send 0x11 then 0x22 back-to-back, ready_i = 0 -> data_o stays 0x11, overrun_o pulses once; raise ready_i -> 0x11 consumed, valid_o drops.
REQ-034 With UART_RX_PARITY_EN defined, send 0x01 with parity bit 0 -> parity_err_o pulse, no valid_o; with parity bit 1 -> data_o = 0x01.
REQ-035 Assert rst_n low during data bit 3 of 0xFF -> outputs reset immediately; after release, send 0x5A -> data_o = 0x5A.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8-bit serial receiver with a single-entry output buffer.
// Frame: start + 8 data bits (LSB first) + optional even parity + stop.
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state and
// parity checking; without it parity_err_o is tied low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic            rx_s;
  logic [TW-1:0]   timer_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            half_tick, full_tick;
  logic            sample_data, stop_tick;
  logic            par_bad;

  assign rx_s      = sync_q[1];
  assign half_tick = (timer_q == HALF_M1);
  assign full_tick = (timer_q == FULL_M1);

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!rx_s) state_d = START;
      START:     if (half_tick) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (full_tick && bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (full_tick) state_d = STOP;
`endif
      STOP:      if (full_tick) state_d = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output decode: per-state sampling strobes for the datapath
  always_comb begin
    sample_data = 1'b0;
    stop_tick   = 1'b0;
    case (state_q)
      DATA:    sample_data = full_tick;
      STOP:    stop_tick   = full_tick;
      default: ;
    endcase
  end

  // Bit timer: zero on every state entry, wraps each bit period inside DATA
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                       timer_q <= '0;
    else if (state_d != state_q || state_q == IDLE)   timer_q <= '0;
    else if (full_tick)                               timer_q <= '0;
    else                                              timer_q <= timer_q + 1'b1;
  end

  // Data shift register, LSB arrives first so shift in from the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else if (state_q == IDLE) begin
      bit_cnt_q <= 3'd0;
    end else if (sample_data) begin
      shift_q   <= {rx_s, shift_q[7:1]};
      bit_cnt_q <= bit_cnt_q + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_q;

  // Capture the received parity bit at mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  par_bit_q <= 1'b0;
    else if (state_q == PARITY && full_tick)     par_bit_q <= rx_s;
  end

  // Even parity: the parity bit equals the XOR of the data bits
  assign par_bad = (par_bit_q != ^shift_q);
`else
  assign par_bad = 1'b0;
`endif

  // Output buffer and one-cycle status pulses, all resolved at the stop sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_o       <= 8'h00;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (stop_tick) begin
        if (!rx_s)                     frame_err_o  <= 1'b1;
        else if (par_bad)              parity_err_o <= 1'b1;
        else if (valid_o && !ready_i)  overrun_o    <= 1'b1;
        else begin
          // A consume in this same cycle is overridden by the new byte
          data_o  <= shift_q;
          valid_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at CLKS_PER_BIT = 16. Stimulus pushes the
// expected bytes and pulse counts; a negedge monitor consumes them.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       parity_err_o;
  logic       overrun_o;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  int exp_ferr = 0;
  int exp_perr = 0;
  int exp_ovr  = 0;
  logic prev_valid = 1'b0;
  logic [7:0] e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) tick();
  endtask

  // start, 8 data LSB first, optional parity (pflip corrupts it), stop
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pflip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ pflip);
`else
    if (pflip) $display("note: parity flip ignored, parity not built");
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // Monitor: consumes expectations whenever the DUT presents an event
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_delivery: got 0x%0h, expected none", data_o);
        end else begin
          e = exp_q.pop_front();
          chk("delivery_data", 32'(data_o), 32'(e));
        end
      end
      if (frame_err_o) begin
        chk("frame_err_expected", 32'(exp_ferr > 0), 32'd1);
        if (exp_ferr > 0) exp_ferr--;
      end
      if (parity_err_o) begin
        chk("parity_err_expected", 32'(exp_perr > 0), 32'd1);
        if (exp_perr > 0) exp_perr--;
      end
      if (overrun_o) begin
        chk("overrun_expected", 32'(exp_ovr > 0), 32'd1);
        if (exp_ovr > 0) exp_ovr--;
      end
      if (frame_err_o || parity_err_o || overrun_o)
        chk("pulse_with_delivery", 32'(valid_o && !prev_valid), 32'd0);
      prev_valid = valid_o;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    ready_i = 1'b1;
    repeat (3) tick();
    chk("rst_data", 32'(data_o), 32'h00);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ferr", 32'(frame_err_o), 32'd0);
    chk("rst_perr", 32'(parity_err_o), 32'd0);
    chk("rst_ovr", 32'(overrun_o), 32'd0);
    rst_n = 1'b1;
    idle(5);

    // Clean frame
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(32);

    // Short low glitch is rejected
    rx = 1'b0;
    repeat (4) tick();
    idle(40);
    chk("glitch_valid", 32'(valid_o), 32'd0);

    // Framing error, line held low, then recovery
    exp_ferr++;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    chk("ferr_no_valid", 32'(valid_o), 32'd0);
    idle(32);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(32);

    // Back-to-back with stalled consumer: second byte overruns
    ready_i = 1'b0;
    exp_q.push_back(8'h11);
    exp_ovr++;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    idle(32);
    chk("hold_data", 32'(data_o), 32'h11);
    chk("hold_valid", 32'(valid_o), 32'd1);
    ready_i = 1'b1;
    tick();
    tick();
    chk("valid_drops", 32'(valid_o), 32'd0);

`ifdef UART_RX_PARITY_EN
    exp_perr++;
    send_frame(8'h01, 1'b1, 1'b1);
    idle(32);
    chk("perr_no_valid", 32'(valid_o), 32'd0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(32);
`endif

    // Reset during data bit 3 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (CPB/2) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_data", 32'(data_o), 32'h00);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    idle(32);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(32);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) tick();
    chk("drain_bytes", 32'(exp_q.size()), 32'd0);
    chk("drain_ferr", 32'(exp_ferr), 32'd0);
    chk("drain_perr", 32'(exp_perr), 32'd0);
    chk("drain_ovr", 32'(exp_ovr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
